// File: rtl/scfifo_wr_arb.sv
// scfifo_wr_arb: round-robin write arbiter that lets NREQ requesters share one
// single-clock FIFO write port. The winner owns the port for up to BURST beats.
// A full or almost-full FIFO pauses the owner without taking ownership away.
// Optional per-requester beat statistics are built when the macro
// SCFIFO_WR_ARB_STATS_EN is defined. Otherwise stat_beats reads as zero.
module scfifo_wr_arb #(
    parameter int NREQ   = 4,
    parameter int WIDTH  = 16,
    parameter int SIZE   = 32,
    parameter int UWIDTH = $clog2(SIZE),
    parameter int BURST  = 4,
    parameter int AFULL  = SIZE - 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*WIDTH-1:0]     req_data,
    output logic [NREQ-1:0]           grant,
    output logic                      fifo_write,
    output logic [WIDTH-1:0]          fifo_data,
    input  logic                      fifo_full,
    input  logic [UWIDTH-1:0]         fifo_used,
    output logic [$clog2(NREQ)-1:0]   owner,
    output logic                      busy,
    output logic [NREQ*16-1:0]        stat_beats
);

    localparam int OWIDTH = $clog2(NREQ);
    localparam int unsigned AFULL_U = AFULL;

    typedef enum logic {IDLE, LOCK} state_t;

    state_t              state_reg, state_next;
    logic [OWIDTH-1:0]   owner_reg, owner_next;
    logic [OWIDTH-1:0]   rr_ptr_reg, rr_ptr_next;
    logic [7:0]          beat_cnt_reg, beat_cnt_next;

    logic                stall;
    logic                lock_active;
    logic                granted;
    logic                last_beat;
    logic                req_owner;
    logic [OWIDTH-1:0]   winner;
    logic                winner_valid;
    int                  idx;
    logic [WIDTH-1:0]    slice [NREQ];

    // The FIFO is treated as unable to accept data when full or at/over the almost-full level.
    assign stall       = fifo_full || (32'(fifo_used) >= AFULL_U);
    assign lock_active = (state_reg == LOCK) && !rst;
    assign req_owner   = req[owner_reg];
    assign granted     = |grant;
    assign last_beat   = (beat_cnt_reg + 8'd1) == 8'(BURST);

    // Split the packed data bus into per-requester words, and grant only the owner.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
        assign slice[gi] = req_data[gi*WIDTH +: WIDTH];
        assign grant[gi] = lock_active && (owner_reg == OWIDTH'(gi)) && req[gi] && !stall;
    end

    assign fifo_write = granted;
    assign fifo_data  = slice[owner_reg];
    assign owner      = owner_reg;
    assign busy       = (state_reg == LOCK);

    // Cyclic search for the first requester after rr_ptr. The scan runs from the farthest
    // candidate to the nearest, so the nearest requesting index is the one that remains.
    always_comb begin
        winner       = '0;
        winner_valid = 1'b0;
        idx          = 0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = (int'(rr_ptr_reg) + k) % NREQ;
            if (req[OWIDTH'(idx)]) begin
                winner       = OWIDTH'(idx);
                winner_valid = 1'b1;
            end
        end
    end

    // Next-state logic: take ownership from IDLE, and in LOCK count beats and release.
    always_comb begin
        state_next    = state_reg;
        owner_next    = owner_reg;
        rr_ptr_next   = rr_ptr_reg;
        beat_cnt_next = beat_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (winner_valid) begin
                    state_next    = LOCK;
                    owner_next    = winner;
                    beat_cnt_next = 8'd0;
                end
            end
            LOCK: begin
                if (granted) begin
                    beat_cnt_next = beat_cnt_reg + 8'd1;
                    if (last_beat) begin
                        state_next  = IDLE;
                        rr_ptr_next = owner_reg;
                    end
                end else if (!req_owner) begin
                    state_next  = IDLE;
                    rr_ptr_next = owner_reg;
                end
                // A stall with the request still held keeps every register unchanged.
            end
            default: state_next = IDLE;
        endcase
    end

    // State registers. Reset makes requester 0 the first winner.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            owner_reg    <= '0;
            rr_ptr_reg   <= OWIDTH'(NREQ - 1);
            beat_cnt_reg <= 8'd0;
        end else begin
            state_reg    <= state_next;
            owner_reg    <= owner_next;
            rr_ptr_reg   <= rr_ptr_next;
            beat_cnt_reg <= beat_cnt_next;
        end
    end

`ifdef SCFIFO_WR_ARB_STATS_EN
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_stats
        logic [15:0] cnt_reg;
        // Saturating count of the beats granted to this requester.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_reg <= 16'd0;
            end else if (grant[gi] && (cnt_reg != 16'hFFFF)) begin
                cnt_reg <= cnt_reg + 16'd1;
            end
        end
        assign stat_beats[gi*16 +: 16] = cnt_reg;
    end
`else
    assign stat_beats = '0;
`endif

endmodule
